// File: rtl/console_pkg.sv
// Shared constants, control codes and state encoding for the text-console write controller.
package console_pkg;

   localparam int COLS         = 64;
   localparam int ROWS         = 24;
   localparam int SCREEN_BYTES = COLS * ROWS;
   localparam logic [7:0] FILL_CHAR = 8'h20;

   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;
   localparam logic [7:0] BS = 8'h08;
   localparam logic [7:0] FF = 8'h0C;
   localparam logic [7:0] HT = 8'h09;

   typedef enum logic [1:0] {
      CLEAR    = 2'd0,
      CLR_LINE = 2'd1,
      IDLE     = 2'd2,
      TAB      = 2'd3
   } console_state_t;

   function automatic logic is_printable(input logic [7:0] c);
      return (c >= 8'h20) && (c <= 8'h7E);
   endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor position registers: advance, carriage return, backspace, line feed and home,
// with row wrap-around at the bottom of the screen.
module console_cursor
   import console_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       advance,
   input  logic       carriage_return,
   input  logic       line_feed,
   input  logic       back,
   input  logic       home,
   output logic [5:0] col,
   output logic [4:0] row,
   output logic       wrap_to_new_line
);

   logic last_col;
   logic last_row;

   assign last_col         = (col == 6'(COLS - 1));
   assign last_row         = (row == 5'(ROWS - 1));
   assign wrap_to_new_line = line_feed || (advance && last_col);

   // Home takes priority so a finishing full clear always lands at 0/0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (home) begin
         col <= '0;
         row <= '0;
      end else if (wrap_to_new_line) begin
         col <= '0;
         row <= last_row ? 5'd0 : row + 5'd1;
      end else if (advance) begin
         col <= col + 6'd1;
      end else if (carriage_return) begin
         col <= '0;
      end else if (back && (col != 6'd0)) begin
         col <= col - 6'd1;
      end
   end

endmodule

// File: rtl/console_write_ctrl.sv
// Text-console write controller: CPU char handshake, control codes, line/screen clears.
// Optional tab expansion is built when CONSOLE_TAB_EXPAND_EN is defined.
module console_write_ctrl
   import console_pkg::*;
(
   input  logic        CLK_CPU,
   input  logic        reset,
   input  logic        char_valid,
   input  logic [7:0]  char_data,
   output logic        char_ready,
   output logic        video_write_enable,
   output logic [7:0]  video_write_data,
   output logic [10:0] video_write_addr,
   output logic [5:0]  cursor_col,
   output logic [4:0]  cursor_row,
   output logic        busy
);

   console_state_t state, state_next;
   logic [10:0] fill_cnt, fill_cnt_next;
   logic        we_next;
   logic [7:0]  data_next;
   logic [10:0] addr_next;
   logic        accept;
   logic        cur_advance, cur_cr, cur_lf, cur_back, cur_home;
   logic        wrap_to_new_line;
   logic [10:0] line_base;
   logic [10:0] cursor_addr;

   assign accept      = char_valid && char_ready;
   assign line_base   = 11'(cursor_row) * 11'(COLS);
   assign cursor_addr = line_base + {5'd0, cursor_col};

   console_cursor u_cursor (
      .clk              (CLK_CPU),
      .rst_n            (reset),
      .advance          (cur_advance),
      .carriage_return  (cur_cr),
      .line_feed        (cur_lf),
      .back             (cur_back),
      .home             (cur_home),
      .col              (cursor_col),
      .row              (cursor_row),
      .wrap_to_new_line (wrap_to_new_line)
   );

   // Cursor control decode, kept apart from the FSM so the wrap event can feed next-state.
   always_comb begin
      cur_advance = 1'b0;
      cur_cr      = 1'b0;
      cur_lf      = 1'b0;
      cur_back    = 1'b0;
      cur_home    = 1'b0;
      case (state)
         CLEAR: cur_home = (fill_cnt == 11'(SCREEN_BYTES - 1));
`ifdef CONSOLE_TAB_EXPAND_EN
         TAB:   cur_advance = 1'b1;
`endif
         IDLE: begin
            if (accept) begin
               if (is_printable(char_data)) cur_advance = 1'b1;
               else if (char_data == CR)    cur_cr      = 1'b1;
               else if (char_data == LF)    cur_lf      = 1'b1;
               else if (char_data == BS)    cur_back    = (cursor_col != 6'd0);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_next    = state;
      fill_cnt_next = fill_cnt;
      we_next       = 1'b0;
      data_next     = video_write_data;
      addr_next     = video_write_addr;
      case (state)
         CLEAR: begin
            we_next       = 1'b1;
            data_next     = FILL_CHAR;
            addr_next     = fill_cnt;
            fill_cnt_next = fill_cnt + 11'd1;
            if (cur_home) begin
               state_next    = IDLE;
               fill_cnt_next = '0;
            end
         end
         CLR_LINE: begin
            we_next       = 1'b1;
            data_next     = FILL_CHAR;
            addr_next     = line_base + fill_cnt;
            fill_cnt_next = fill_cnt + 11'd1;
            if (fill_cnt == 11'(COLS - 1)) begin
               state_next    = IDLE;
               fill_cnt_next = '0;
            end
         end
`ifdef CONSOLE_TAB_EXPAND_EN
         TAB: begin
            we_next   = 1'b1;
            data_next = FILL_CHAR;
            addr_next = cursor_addr;
            if (cursor_col[2:0] == 3'd7) state_next = IDLE;
         end
`endif
         IDLE: begin
            if (accept) begin
               if (cur_advance) begin
                  we_next   = 1'b1;
                  data_next = char_data;
                  addr_next = cursor_addr;
               end else if (cur_back) begin
                  we_next   = 1'b1;
                  data_next = FILL_CHAR;
                  addr_next = cursor_addr - 11'd1;
               end else if (char_data == FF) begin
                  state_next = CLEAR;
`ifdef CONSOLE_TAB_EXPAND_EN
               end else if (char_data == HT) begin
                  state_next = TAB;
`endif
               end
            end
         end
         default: state_next = CLEAR;
      endcase
      if (wrap_to_new_line) state_next = CLR_LINE;
   end

   // Every output is a register; ready/busy are derived from the state being entered.
   always_ff @(posedge CLK_CPU or negedge reset) begin
      if (!reset) begin
         state              <= CLEAR;
         fill_cnt           <= '0;
         video_write_enable <= 1'b0;
         video_write_data   <= 8'h00;
         video_write_addr   <= '0;
         char_ready         <= 1'b0;
         busy               <= 1'b1;
      end else begin
         state              <= state_next;
         fill_cnt           <= fill_cnt_next;
         video_write_enable <= we_next;
         video_write_data   <= data_next;
         video_write_addr   <= addr_next;
         char_ready         <= (state_next == IDLE);
         busy               <= (state_next != IDLE);
      end
   end

endmodule

// File: tb/tb_console_write_ctrl.sv
// Self-checking bench for console_write_ctrl: table of single-character vectors plus
// hand-written sequences for clears, line wrap, backspace, reset abort and tab expansion.
module tb_console_write_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        char_valid;
   logic [7:0]  char_data;
   logic        char_ready;
   logic        video_write_enable;
   logic [7:0]  video_write_data;
   logic [10:0] video_write_addr;
   logic [5:0]  cursor_col;
   logic [4:0]  cursor_row;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wa[$];
   int wd[$];
   int wc[$];

   typedef struct {
      logic [7:0] ch;
      int         n_wr;
      int         addr;
      int         data;
      int         col;
      int         row;
   } vec_t;

   vec_t vec[13];

   console_write_ctrl dut (
      .CLK_CPU            (clk),
      .reset              (reset),
      .char_valid         (char_valid),
      .char_data          (char_data),
      .char_ready         (char_ready),
      .video_write_enable (video_write_enable),
      .video_write_data   (video_write_data),
      .video_write_addr   (video_write_addr),
      .cursor_col         (cursor_col),
      .cursor_row         (cursor_row),
      .busy               (busy)
   );

   always #5 clk = ~clk;

   // Write monitor samples just after each rising edge.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (reset && video_write_enable) begin
         wa.push_back(int'(video_write_addr));
         wd.push_back(int'(video_write_data));
         wc.push_back(cyc);
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic clearLog();
      wa.delete();
      wd.delete();
      wc.delete();
   endtask

   task automatic waitReady(input string name, input int limit, output int n);
      n = 0;
      while (!char_ready && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (!char_ready) checkOutput({name, "_timeout"}, 0, 1);
   endtask

   task automatic applyStimulus(input logic [7:0] c);
      int n;
      char_valid = 1'b1;
      char_data  = c;
      waitReady("send", 5000, n);
      @(negedge clk);
      char_valid = 1'b0;
   endtask

   task automatic checkFill(input string name, input int count, input int base);
      int bad = 0;
      checkOutput({name, "_count"}, wa.size(), count);
      foreach (wa[i]) if (wa[i] != base + i || wd[i] != 32'h20) bad++;
      checkOutput({name, "_seq"}, bad, 0);
   endtask

   initial begin
      int n;
      int bad;

      vec[0]  = '{8'h41, 1, 0, 8'h41, 1, 0};
      vec[1]  = '{8'h42, 1, 1, 8'h42, 2, 0};
      vec[2]  = '{8'h20, 1, 2, 8'h20, 3, 0};
      vec[3]  = '{8'h7E, 1, 3, 8'h7E, 4, 0};
      vec[4]  = '{8'h0D, 0, 0, 0,     0, 0};
      vec[5]  = '{8'h78, 1, 0, 8'h78, 1, 0};
      vec[6]  = '{8'h08, 1, 0, 8'h20, 0, 0};
      vec[7]  = '{8'h08, 0, 0, 0,     0, 0};
      vec[8]  = '{8'h7F, 0, 0, 0,     0, 0};
      vec[9]  = '{8'h80, 0, 0, 0,     0, 0};
      vec[10] = '{8'h1F, 0, 0, 0,     0, 0};
      vec[11] = '{8'h5A, 1, 0, 8'h5A, 1, 0};
`ifdef CONSOLE_TAB_EXPAND_EN
      vec[12] = '{8'h09, 7, 1, 8'h20, 8, 0};
`else
      vec[12] = '{8'h09, 0, 0, 0,     1, 0};
`endif

      reset      = 1'b0;
      char_valid = 1'b0;
      char_data  = 8'h00;
      repeat (2) @(negedge clk);
      checkOutput("rst_we",    video_write_enable, 0);
      checkOutput("rst_data",  video_write_data, 0);
      checkOutput("rst_addr",  video_write_addr, 0);
      checkOutput("rst_ready", char_ready, 0);
      checkOutput("rst_col",   cursor_col, 0);
      checkOutput("rst_row",   cursor_row, 0);
      checkOutput("rst_busy",  busy, 1);

      reset = 1'b1;
      clearLog();
      waitReady("init", 3000, n);
      checkFill("init_clear", 1536, 0);
      checkOutput("init_col",  cursor_col, 0);
      checkOutput("init_row",  cursor_row, 0);
      checkOutput("init_busy", busy, 0);

      for (int i = 0; i < 13; i++) begin
         clearLog();
         applyStimulus(vec[i].ch);
         waitReady("vec", 100, n);
         checkOutput($sformatf("v%0d_writes", i), wa.size(), vec[i].n_wr);
         if (vec[i].n_wr > 0 && wa.size() > 0) begin
            bad = 0;
            foreach (wa[k]) if (wa[k] != vec[i].addr + k || wd[k] != vec[i].data) bad++;
            checkOutput($sformatf("v%0d_wr", i), bad, 0);
         end
         checkOutput($sformatf("v%0d_col", i), cursor_col, vec[i].col);
         checkOutput($sformatf("v%0d_row", i), cursor_row, vec[i].row);
      end

      // 64 back-to-back characters across row 0, then the line clear of row 1.
      applyStimulus(8'h0D);
      clearLog();
      for (int i = 0; i < 64; i++) applyStimulus(8'h61 + 8'(i % 26));
      checkOutput("wrap_busy", busy, 1);
      n = 0;
      while (!char_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("wrap_ready_low", n, 64);
      checkOutput("wrap_count", wa.size(), 128);
      bad = 0;
      for (int i = 0; i < 128 && i < wa.size(); i++) begin
         if (i < 64 && (wa[i] != i || wd[i] != 32'h61 + (i % 26))) bad++;
         if (i >= 64 && (wa[i] != i || wd[i] != 32'h20)) bad++;
         if (i > 0 && wc[i] - wc[i-1] != 1) bad++;
      end
      checkOutput("wrap_seq", bad, 0);
      checkOutput("wrap_col", cursor_col, 0);
      checkOutput("wrap_row", cursor_row, 1);

      // Backspace at 5/3 and at column 0.
      applyStimulus(8'h0A);
      applyStimulus(8'h0A);
      for (int i = 0; i < 5; i++) applyStimulus(8'h71);
      clearLog();
      applyStimulus(8'h08);
      checkOutput("bs_count", wa.size(), 1);
      if (wa.size() > 0) begin
         checkOutput("bs_addr", wa[0], 196);
         checkOutput("bs_data", wd[0], 32'h20);
      end
      checkOutput("bs_col", cursor_col, 4);
      checkOutput("bs_row", cursor_row, 3);
      applyStimulus(8'h0D);
      clearLog();
      applyStimulus(8'h08);
      checkOutput("bs0_count", wa.size(), 0);
      checkOutput("bs0_col", cursor_col, 0);
      checkOutput("bs0_row", cursor_row, 3);

      // Bottom row LF wraps to row 0 and clears it; then a form feed clears the screen.
      for (int i = 0; i < 20; i++) applyStimulus(8'h0A);
      waitReady("lf", 200, n);
      checkOutput("row23", cursor_row, 23);
      clearLog();
      applyStimulus(8'h0A);
      waitReady("lfwrap", 200, n);
      checkFill("lfwrap", 64, 0);
      checkOutput("lfwrap_row", cursor_row, 0);
      applyStimulus(8'h4B);
      applyStimulus(8'h4B);
      clearLog();
      applyStimulus(8'h0C);
      waitReady("ff", 3000, n);
      checkFill("ff", 1536, 0);
      checkOutput("ff_col", cursor_col, 0);
      checkOutput("ff_row", cursor_row, 0);

      // Reset in the middle of a full clear.
      applyStimulus(8'h0C);
      n = 0;
      while (!(video_write_enable && video_write_addr == 11'd700) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("mid_addr", video_write_addr, 700);
      reset = 1'b0;
      #1;
      checkOutput("mid_we",    video_write_enable, 0);
      checkOutput("mid_addr0", video_write_addr, 0);
      checkOutput("mid_busy",  busy, 1);
      checkOutput("mid_ready", char_ready, 0);
      @(negedge clk);
      reset = 1'b1;
      clearLog();
      waitReady("restart", 3000, n);
      checkFill("restart", 1536, 0);

`ifdef CONSOLE_TAB_EXPAND_EN
      applyStimulus(8'h61);
      applyStimulus(8'h62);
      applyStimulus(8'h63);
      clearLog();
      applyStimulus(8'h09);
      waitReady("tab", 100, n);
      checkFill("tab", 5, 3);
      checkOutput("tab_col", cursor_col, 8);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
